// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow, asynchronous square wave in clk_in cycles,
// with a one-cycle result strobe and a stall flag when rising edges stop arriving.
module clk_period_meter #(
    parameter int unsigned      CNT_W   = 16,
    parameter logic [CNT_W-1:0] TIMEOUT = CNT_W'(50000)
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             stalled
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MEAS  = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic s1;
    logic s2;
    logic s3;
    logic rise;
    logic fall;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] hhold;

    logic cnt_load;
    logic cnt_run;
    logic report;

    // s1/s2 resynchronise sig_in; s3 is history for edge detection only.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A rise always wins over a timeout landing in the same cycle.
    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_run  = 1'b0;
        report   = 1'b0;
        if (!en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_d  = MEAS;
                        cnt_load = 1'b1;
                    end
                end
                MEAS: begin
                    if (rise) begin
                        cnt_load = 1'b1;
                        report   = 1'b1;
                    end else begin
                        cnt_run = 1'b1;
                        if (cnt == TIMEOUT) begin
                            state_d = STALL;
                        end
                    end
                end
                STALL: begin
                    if (rise) begin
                        state_d  = MEAS;
                        cnt_load = 1'b1;
                    end else begin
                        cnt_run = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            hcnt  <= '0;
            hhold <= '0;
        end else begin
            if (cnt_load) begin
                cnt  <= CNT_W'(1);
                hcnt <= CNT_W'(1);
            end else if (cnt_run) begin
                if (cnt != TIMEOUT) begin
                    cnt <= cnt + 1'b1;
                end
                if (s2 && (hcnt != TIMEOUT)) begin
                    hcnt <= hcnt + 1'b1;
                end
            end
            if (fall && cnt_run) begin
                hhold <= hcnt;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            stalled    <= 1'b0;
        end else begin
            meas_valid <= report;
            stalled    <= (state_d == STALL);
            if (report) begin
                period    <= cnt;
                high_time <= hhold;
            end
        end
    end

endmodule

// File: tb/tb_clk_period_meter.sv
// Bench for clk_period_meter: waveforms are built as per-cycle sample lists and every
// cycle is checked against an edge-level model of which intervals should be reported.
`timescale 1ns/1ps
module tb_clk_period_meter;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 100;

    logic             clk_in = 1'b0;
    logic             rst    = 1'b1;
    logic             en     = 1'b0;
    logic             sig_in = 1'b0;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             stalled;

    clk_period_meter #(
        .CNT_W  (CNT_W),
        .TIMEOUT(CNT_W'(TIMEOUT))
    ) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .en        (en),
        .sig_in    (sig_in),
        .period    (period),
        .high_time (high_time),
        .meas_valid(meas_valid),
        .stalled   (stalled)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: sampled sig_in history since reset, edge of last accepted rise.
    bit               hist[$];
    int               prev_rise;
    int               cur_edge;
    logic             exp_valid;
    logic             exp_stalled;
    logic [CNT_W-1:0] exp_period;
    logic [CNT_W-1:0] exp_high;
    logic [1:0]       wave_q[$];   // {en, sig_in} per cycle

    function automatic bit smp(input int i);
        if (i < 0 || i >= hist.size()) return 1'b0;
        return hist[i];
    endfunction

    function automatic int high_run(input int start);
        int n = 0;
        for (int j = start; j < hist.size() && hist[j]; j++) n++;
        return n;
    endfunction

    task automatic model_reset();
        hist.delete();
        prev_rise   = -1;
        cur_edge    = -1;
        exp_valid   = 1'b0;
        exp_stalled = 1'b0;
        exp_period  = '0;
        exp_high    = '0;
    endtask

    task automatic add_level(input bit lvl, input int len, input bit e_v);
        for (int i = 0; i < len; i++) wave_q.push_back({e_v, lvl});
    endtask

    task automatic add_square(input int n, input int h, input int reps, input bit e_v);
        for (int r = 0; r < reps; r++) begin
            add_level(1'b1, h, e_v);
            add_level(1'b0, n - h, e_v);
        end
    endtask

    // Drive one cycle, then predict outputs after the edge. A rise seen at edge e means
    // sig_in was sampled 0 then 1 at edges e-3, e-2. An interval is reported only if it
    // began at an accepted rise, en stayed high, and it is no longer than TIMEOUT.
    task automatic cycle(input bit s, input bit e_v);
        bit is_rise;
        @(negedge clk_in);
        sig_in = s;
        en     = e_v;
        @(posedge clk_in);
        hist.push_back(s);
        cur_edge  = hist.size() - 1;
        is_rise   = smp(cur_edge - 2) && !smp(cur_edge - 3);
        exp_valid = 1'b0;
        if (!e_v) begin
            prev_rise = -1;
        end else if (is_rise) begin
            if (prev_rise >= 0 && cur_edge - prev_rise <= TIMEOUT) begin
                exp_valid  = 1'b1;
                exp_period = CNT_W'(cur_edge - prev_rise);
                exp_high   = CNT_W'(high_run(prev_rise - 2));
            end
            prev_rise = cur_edge;
        end
        exp_stalled = e_v && prev_rise >= 0 && !is_rise && (cur_edge - prev_rise >= TIMEOUT);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk_in);
        #1;
        n_checks++;
        if ({meas_valid, stalled, period, high_time} !== '0) begin
            $display("FAIL reset_state: valid=%b stalled=%b period=%0d high=%0d, expected all 0",
                     meas_valid, stalled, period, high_time);
        end else n_pass++;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_div2();
        int pulses = 0;
        add_level(1'b0, 2, 1'b0);
        add_square(2, 1, 10, 1'b1);
        add_level(1'b0, 4, 1'b1);
        while (wave_q.size() > 0) begin
            logic [1:0] w = wave_q.pop_front();
            cycle(w[0], w[1]);
            if (meas_valid === 1'b1) pulses++;
            n_checks++;
            if ({meas_valid, stalled, period, high_time} !== {exp_valid, exp_stalled, exp_period, exp_high}) begin
                $display("FAIL div2 edge %0d: valid=%b stalled=%b period=%0d high=%0d, expected valid=%b stalled=%b period=%0d high=%0d",
                         cur_edge, meas_valid, stalled, period, high_time, exp_valid, exp_stalled, exp_period, exp_high);
            end else n_pass++;
        end
        n_checks++;
        if (pulses != 9) $display("FAIL div2_pulse_count: got %0d, expected 9", pulses);
        else n_pass++;
    endtask

    task automatic test_square();
        int pulses = 0;
        int last   = -1;
        add_level(1'b0, 2, 1'b0);
        add_square(10, 3, 5, 1'b1);
        add_level(1'b0, 4, 1'b1);
        while (wave_q.size() > 0) begin
            logic [1:0] w = wave_q.pop_front();
            cycle(w[0], w[1]);
            n_checks++;
            if ({meas_valid, stalled, period, high_time} !== {exp_valid, exp_stalled, exp_period, exp_high}) begin
                $display("FAIL square edge %0d: valid=%b stalled=%b period=%0d high=%0d, expected valid=%b stalled=%b period=%0d high=%0d",
                         cur_edge, meas_valid, stalled, period, high_time, exp_valid, exp_stalled, exp_period, exp_high);
            end else n_pass++;
            if (meas_valid === 1'b1) begin
                pulses++;
                if (last >= 0) begin
                    n_checks++;
                    if (cur_edge - last != 10) $display("FAIL square_spacing: got %0d, expected 10", cur_edge - last);
                    else n_pass++;
                end
                last = cur_edge;
            end
        end
        n_checks++;
        if (pulses != 4) $display("FAIL square_pulse_count: got %0d, expected 4", pulses);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int last_pulse = -1;
        int stall_edge = -1;
        add_level(1'b0, 2, 1'b0);
        add_square(10, 3, 3, 1'b1);
        add_level(1'b0, 120, 1'b1);
        add_square(10, 3, 3, 1'b1);
        while (wave_q.size() > 0) begin
            logic [1:0] w = wave_q.pop_front();
            cycle(w[0], w[1]);
            if (meas_valid === 1'b1 && stall_edge < 0) last_pulse = cur_edge;
            if (stalled === 1'b1 && stall_edge < 0) stall_edge = cur_edge;
            n_checks++;
            if ({meas_valid, stalled, period, high_time} !== {exp_valid, exp_stalled, exp_period, exp_high}) begin
                $display("FAIL timeout edge %0d: valid=%b stalled=%b period=%0d high=%0d, expected valid=%b stalled=%b period=%0d high=%0d",
                         cur_edge, meas_valid, stalled, period, high_time, exp_valid, exp_stalled, exp_period, exp_high);
            end else n_pass++;
        end
        n_checks++;
        if (stall_edge - last_pulse != TIMEOUT)
            $display("FAIL timeout_latency: got %0d, expected %0d", stall_edge - last_pulse, TIMEOUT);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        int pulses = 0;
        add_level(1'b0, 2, 1'b0);
        add_square(10, 3, 3, 1'b1);
        add_level(1'b1, 2, 1'b1);
        while (wave_q.size() > 0) begin
            logic [1:0] w = wave_q.pop_front();
            cycle(w[0], w[1]);
            n_checks++;
            if ({meas_valid, stalled, period, high_time} !== {exp_valid, exp_stalled, exp_period, exp_high}) begin
                $display("FAIL pre_reset edge %0d: valid=%b stalled=%b period=%0d high=%0d, expected valid=%b stalled=%b period=%0d high=%0d",
                         cur_edge, meas_valid, stalled, period, high_time, exp_valid, exp_stalled, exp_period, exp_high);
            end else n_pass++;
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({meas_valid, stalled, period, high_time} !== '0) begin
            $display("FAIL async_reset: valid=%b stalled=%b period=%0d high=%0d, expected all 0",
                     meas_valid, stalled, period, high_time);
        end else n_pass++;
        repeat (2) @(posedge clk_in);
        #1 rst = 1'b0;
        model_reset();
        add_square(10, 3, 3, 1'b1);
        add_level(1'b0, 4, 1'b1);
        while (wave_q.size() > 0) begin
            logic [1:0] w = wave_q.pop_front();
            cycle(w[0], w[1]);
            if (meas_valid === 1'b1) pulses++;
            n_checks++;
            if ({meas_valid, stalled, period, high_time} !== {exp_valid, exp_stalled, exp_period, exp_high}) begin
                $display("FAIL post_reset edge %0d: valid=%b stalled=%b period=%0d high=%0d, expected valid=%b stalled=%b period=%0d high=%0d",
                         cur_edge, meas_valid, stalled, period, high_time, exp_valid, exp_stalled, exp_period, exp_high);
            end else n_pass++;
        end
        n_checks++;
        if (pulses != 2) $display("FAIL post_reset_pulse_count: got %0d, expected 2", pulses);
        else n_pass++;
    endtask

    task automatic test_enable();
        add_level(1'b0, 2, 1'b0);
        add_square(10, 3, 3, 1'b1);
        add_square(10, 3, 2, 1'b0);
        add_square(10, 3, 3, 1'b1);
        add_level(1'b0, 4, 1'b1);
        while (wave_q.size() > 0) begin
            logic [1:0] w = wave_q.pop_front();
            cycle(w[0], w[1]);
            n_checks++;
            if ({meas_valid, stalled, period, high_time} !== {exp_valid, exp_stalled, exp_period, exp_high}) begin
                $display("FAIL enable edge %0d: valid=%b stalled=%b period=%0d high=%0d, expected valid=%b stalled=%b period=%0d high=%0d",
                         cur_edge, meas_valid, stalled, period, high_time, exp_valid, exp_stalled, exp_period, exp_high);
            end else n_pass++;
        end
    endtask

    task automatic test_const_high();
        int stall_cycles = 0;
        add_level(1'b0, 2, 1'b0);
        add_level(1'b0, 5, 1'b1);
        add_level(1'b1, 150, 1'b1);
        add_level(1'b0, 5, 1'b1);
        add_level(1'b1, 5, 1'b1);
        add_level(1'b0, 3, 1'b1);
        while (wave_q.size() > 0) begin
            logic [1:0] w = wave_q.pop_front();
            cycle(w[0], w[1]);
            if (stalled === 1'b1) stall_cycles++;
            n_checks++;
            if ({meas_valid, stalled, period, high_time} !== {exp_valid, exp_stalled, exp_period, exp_high}) begin
                $display("FAIL const_high edge %0d: valid=%b stalled=%b period=%0d high=%0d, expected valid=%b stalled=%b period=%0d high=%0d",
                         cur_edge, meas_valid, stalled, period, high_time, exp_valid, exp_stalled, exp_period, exp_high);
            end else n_pass++;
        end
        n_checks++;
        if (stall_cycles == 0) $display("FAIL const_high_stall: got 0 stalled cycles, expected more than 0");
        else n_pass++;
    endtask

    task automatic test_boundary();
        add_level(1'b0, 2, 1'b0);
        add_square(TIMEOUT, 1, 3, 1'b1);
        add_square(TIMEOUT + 1, 1, 2, 1'b1);
        add_square(TIMEOUT - 1, TIMEOUT - 2, 2, 1'b1);
        add_level(1'b0, 3, 1'b1);
        while (wave_q.size() > 0) begin
            logic [1:0] w = wave_q.pop_front();
            cycle(w[0], w[1]);
            n_checks++;
            if ({meas_valid, stalled, period, high_time} !== {exp_valid, exp_stalled, exp_period, exp_high}) begin
                $display("FAIL boundary edge %0d: valid=%b stalled=%b period=%0d high=%0d, expected valid=%b stalled=%b period=%0d high=%0d",
                         cur_edge, meas_valid, stalled, period, high_time, exp_valid, exp_stalled, exp_period, exp_high);
            end else n_pass++;
        end
    endtask

    task automatic test_random();
        add_level(1'b0, 2, 1'b0);
        for (int seg = 0; seg < 40; seg++) begin
            int n = $urandom_range(30, 2);
            int h = $urandom_range(n - 1, 1);
            int sel = $urandom_range(9, 0);
            if (sel == 0) add_level(1'b0, $urandom_range(110, 90), 1'b1);
            else if (sel == 1) add_square(n, h, 1, 1'b0);
            else add_square(n, h, $urandom_range(4, 1), 1'b1);
        end
        add_level(1'b0, 4, 1'b1);
        while (wave_q.size() > 0) begin
            logic [1:0] w = wave_q.pop_front();
            cycle(w[0], w[1]);
            n_checks++;
            if ({meas_valid, stalled, period, high_time} !== {exp_valid, exp_stalled, exp_period, exp_high}) begin
                $display("FAIL random edge %0d: valid=%b stalled=%b period=%0d high=%0d, expected valid=%b stalled=%b period=%0d high=%0d",
                         cur_edge, meas_valid, stalled, period, high_time, exp_valid, exp_stalled, exp_period, exp_high);
            end else n_pass++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_div2();
        test_square();
        test_timeout();
        test_async_reset();
        test_enable();
        test_const_high();
        test_boundary();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
